// File: rtl/cdb_arbiter.sv
// Result-broadcast stage: per-source result FIFOs feeding NUM_CDB registered
// CDB lanes, granted round-robin or by fixed priority from the FIFO heads.
module cdb_arbiter #(
    parameter int NUM_SRC    = 6,
    parameter int NUM_CDB    = 2,
    parameter int BUF_DEPTH  = 2,
    parameter int PRN_W      = 6,
    parameter int ROBN_W     = 5,
    parameter int FIXED_PRIO = 0,
    localparam int SRC_W     = $clog2(NUM_SRC)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        squash,
    input  logic [NUM_SRC-1:0]          in_valid,
    output logic [NUM_SRC-1:0]          in_ready,
    input  logic [NUM_SRC*PRN_W-1:0]    in_prn,
    input  logic [NUM_SRC*32-1:0]       in_value,
    input  logic [NUM_SRC*ROBN_W-1:0]   in_robn,
    output logic [NUM_CDB-1:0]          cdb_valid,
    output logic [NUM_CDB*PRN_W-1:0]    cdb_prn,
    output logic [NUM_CDB*32-1:0]       cdb_value,
    output logic [NUM_CDB*ROBN_W-1:0]   cdb_robn,
    output logic [NUM_CDB*SRC_W-1:0]    cdb_src
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    // FIFO storage and bookkeeping
    logic [PRN_W-1:0]  r_prn  [NUM_SRC][BUF_DEPTH];
    logic [31:0]       r_val  [NUM_SRC][BUF_DEPTH];
    logic [ROBN_W-1:0] r_robn [NUM_SRC][BUF_DEPTH];
    logic [AW-1:0]     r_rd   [NUM_SRC];
    logic [AW-1:0]     r_wr   [NUM_SRC];
    logic [CW-1:0]     r_cnt  [NUM_SRC];
    logic [SRC_W-1:0]  r_rr;

    // Registered lanes
    logic [NUM_CDB-1:0] r_lvld;
    logic [PRN_W-1:0]   r_lprn  [NUM_CDB];
    logic [31:0]        r_lval  [NUM_CDB];
    logic [ROBN_W-1:0]  r_lrobn [NUM_CDB];
    logic [SRC_W-1:0]   r_lsrc  [NUM_CDB];

    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_grant;
    logic [SRC_W-1:0]   w_start;
    logic [SRC_W-1:0]   w_last;
    logic [SRC_W-1:0]   w_rr_nxt;
    logic               w_any;
    logic [NUM_CDB-1:0] w_lvld;
    logic [PRN_W-1:0]   w_lprn  [NUM_CDB];
    logic [31:0]        w_lval  [NUM_CDB];
    logic [ROBN_W-1:0]  w_lrobn [NUM_CDB];
    logic [SRC_W-1:0]   w_lsrc  [NUM_CDB];

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == AW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Readiness looks only at occupancy, never at this cycle's pop
    always_comb begin
        in_ready = '0;
        w_push   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            in_ready[i] = (r_cnt[i] < CW'(BUF_DEPTH));
            w_push[i]   = in_valid[i] && in_ready[i] && !squash;
        end
    end

    assign w_start = (FIXED_PRIO != 0) ? '0 : r_rr;

    always_comb begin
        int n;
        int idx;
        n       = 0;
        idx     = 0;
        w_grant = '0;
        w_lvld  = '0;
        w_any   = 1'b0;
        w_last  = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            w_lprn[k]  = '0;
            w_lval[k]  = '0;
            w_lrobn[k] = '0;
            w_lsrc[k]  = '0;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(w_start) + k) % NUM_SRC;
            if (r_cnt[idx] != '0 && n < NUM_CDB) begin
                w_grant[idx] = 1'b1;
                w_lvld[n]    = 1'b1;
                w_lprn[n]    = r_prn[idx][r_rd[idx]];
                w_lval[n]    = r_val[idx][r_rd[idx]];
                w_lrobn[n]   = r_robn[idx][r_rd[idx]];
                w_lsrc[n]    = SRC_W'(idx);
                w_last       = SRC_W'(idx);
                w_any        = 1'b1;
                n            = n + 1;
            end
        end
    end

    assign w_rr_nxt = (w_last == SRC_W'(NUM_SRC - 1)) ? '0 : w_last + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr <= '0;
        end else if (squash) begin
            r_rr <= '0;
        end else if (w_any) begin
            r_rr <= w_rr_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_rd[i]  <= '0;
                r_wr[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else if (squash) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_rd[i]  <= '0;
                r_wr[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_push[i]) begin
                    r_wr[i] <= f_inc(r_wr[i]);
                end
                if (w_grant[i]) begin
                    r_rd[i] <= f_inc(r_rd[i]);
                end
                if (w_push[i] && !w_grant[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (!w_push[i] && w_grant[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Payload needs no reset: it is only read when the count says valid
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_push[i]) begin
                r_prn[i][r_wr[i]]  <= in_prn[i*PRN_W +: PRN_W];
                r_val[i][r_wr[i]]  <= in_value[i*32 +: 32];
                r_robn[i][r_wr[i]] <= in_robn[i*ROBN_W +: ROBN_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lvld <= '0;
            for (int k = 0; k < NUM_CDB; k++) begin
                r_lprn[k]  <= '0;
                r_lval[k]  <= '0;
                r_lrobn[k] <= '0;
                r_lsrc[k]  <= '0;
            end
        end else if (squash) begin
            r_lvld <= '0;
            for (int k = 0; k < NUM_CDB; k++) begin
                r_lprn[k]  <= '0;
                r_lval[k]  <= '0;
                r_lrobn[k] <= '0;
                r_lsrc[k]  <= '0;
            end
        end else begin
            r_lvld <= w_lvld;
            for (int k = 0; k < NUM_CDB; k++) begin
                r_lprn[k]  <= w_lprn[k];
                r_lval[k]  <= w_lval[k];
                r_lrobn[k] <= w_lrobn[k];
                r_lsrc[k]  <= w_lsrc[k];
            end
        end
    end

    assign cdb_valid = r_lvld;

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
        assign cdb_prn[k*PRN_W +: PRN_W]    = r_lprn[k];
        assign cdb_value[k*32 +: 32]        = r_lval[k];
        assign cdb_robn[k*ROBN_W +: ROBN_W] = r_lrobn[k];
        assign cdb_src[k*SRC_W +: SRC_W]    = r_lsrc[k];
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: round-robin instance plus a fixed-priority
// instance sharing the same stimulus.
module tb_cdb_arbiter;

    localparam int NS = 6;
    localparam int NC = 2;
    localparam int PW = 6;
    localparam int RW = 5;
    localparam int SW = 3;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           squash = 1'b0;
    logic [NS-1:0]  in_valid = '0;
    logic [NS*PW-1:0] in_prn = '0;
    logic [NS*32-1:0] in_value = '0;
    logic [NS*RW-1:0] in_robn = '0;

    logic [NS-1:0]    in_ready, fp_ready;
    logic [NC-1:0]    cdb_valid, fp_valid;
    logic [NC*PW-1:0] cdb_prn, fp_prn;
    logic [NC*32-1:0] cdb_value, fp_value;
    logic [NC*RW-1:0] cdb_robn, fp_robn;
    logic [NC*SW-1:0] cdb_src, fp_src;

    logic [45:0] lane0, lane1, fp_lane0, fp_lane1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    cdb_arbiter #(.FIXED_PRIO(0)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_prn(in_prn), .in_value(in_value), .in_robn(in_robn),
        .cdb_valid(cdb_valid), .cdb_prn(cdb_prn), .cdb_value(cdb_value),
        .cdb_robn(cdb_robn), .cdb_src(cdb_src)
    );

    cdb_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clock(clock), .reset(reset), .squash(squash),
        .in_valid(in_valid), .in_ready(fp_ready),
        .in_prn(in_prn), .in_value(in_value), .in_robn(in_robn),
        .cdb_valid(fp_valid), .cdb_prn(fp_prn), .cdb_value(fp_value),
        .cdb_robn(fp_robn), .cdb_src(fp_src)
    );

    assign lane0 = {cdb_src[2:0], cdb_robn[4:0], cdb_prn[5:0], cdb_value[31:0]};
    assign lane1 = {cdb_src[5:3], cdb_robn[9:5], cdb_prn[11:6], cdb_value[63:32]};
    assign fp_lane0 = {fp_src[2:0], fp_robn[4:0], fp_prn[5:0], fp_value[31:0]};
    assign fp_lane1 = {fp_src[5:3], fp_robn[9:5], fp_prn[11:6], fp_value[63:32]};

    // Expected lane word {src, robn, prn, value}
    function automatic logic [45:0] L(input int s, input int r, input int p,
                                      input logic [31:0] v);
        return {s[2:0], r[4:0], p[5:0], v};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_src(input int i, input int p, input logic [31:0] v,
                           input int r);
        in_prn[i*PW +: PW]   = p[PW-1:0];
        in_value[i*32 +: 32] = v;
        in_robn[i*RW +: RW]  = r[RW-1:0];
    endtask

    task automatic do_reset;
        in_valid = '0;
        squash   = 1'b0;
        reset    = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick();
        n_tests++;
        if (cdb_valid !== 2'b00 || lane0 !== '0 || lane1 !== '0) begin
            n_fail++;
            $display("FAIL reset_lanes got v=%b l0=%h l1=%h want 0", cdb_valid, lane0, lane1);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (in_ready !== 6'h3F || fp_ready !== 6'h3F) begin
            n_fail++;
            $display("FAIL reset_ready got %h/%h want 3f", in_ready, fp_ready);
        end
        for (int i = 0; i < NS; i++) set_src(i, i + 1, 32'hC0 + i, i);
        in_valid = 6'h3F;
        tick();
        in_valid = '0;
        tick();
        n_tests++;
        if (cdb_valid !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_pretraffic got %b want 11", cdb_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (cdb_valid !== 2'b00 || lane0 !== '0 || lane1 !== '0) begin
            n_fail++;
            $display("FAIL reset_async got v=%b l0=%h l1=%h want 0", cdb_valid, lane0, lane1);
        end
        tick();
        reset = 1'b1;
        n_tests++;
        if (in_ready !== 6'h3F) begin
            n_fail++;
            $display("FAIL reset_ready2 got %h want 3f", in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++;
            if (cdb_valid !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_discard c%0d got %b want 00", c, cdb_valid);
            end
        end
    endtask

    task automatic test_single;
        do_reset();
        set_src(3, 5, 32'h2A, 7);
        in_valid = 6'b001000;
        tick();
        in_valid = '0;
        n_tests++;
        if (cdb_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL single_nobypass got %b want 00", cdb_valid);
        end
        tick();
        n_tests++;
        if (cdb_valid !== 2'b01 || lane0 !== L(3, 7, 5, 32'h2A) || lane1 !== '0) begin
            n_fail++;
            $display("FAIL single_lane got v=%b l0=%h l1=%h want v=01 l0=%h l1=0",
                     cdb_valid, lane0, lane1, L(3, 7, 5, 32'h2A));
        end
        tick();
        n_tests++;
        if (cdb_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL single_once got %b want 00", cdb_valid);
        end
    endtask

    // Source 2 carries PRN 0 to cover the no-writeback case
    function automatic logic [45:0] all_exp(input int i);
        return L(i, i + 1, (i == 2) ? 0 : i + 8, 32'hA0 + i);
    endfunction

    task automatic test_all_sources;
        do_reset();
        for (int i = 0; i < NS; i++) set_src(i, (i == 2) ? 0 : i + 8, 32'hA0 + i, i + 1);
        in_valid = 6'h3F;
        tick();
        in_valid = '0;
        for (int p = 0; p < 3; p++) begin
            tick();
            n_tests++;
            if (cdb_valid !== 2'b11 || lane0 !== all_exp(2 * p) || lane1 !== all_exp(2 * p + 1)) begin
                n_fail++;
                $display("FAIL all_pair%0d got v=%b l0=%h l1=%h want 11 %h %h", p,
                         cdb_valid, lane0, lane1, all_exp(2 * p), all_exp(2 * p + 1));
            end
        end
        tick();
        n_tests++;
        if (cdb_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL all_drained got %b want 00", cdb_valid);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        set_src(0, 1, 32'h10, 1);
        set_src(1, 2, 32'h11, 2);
        in_valid = 6'b000011;
        tick();
        in_valid = '0;
        tick();
        tick();
        set_src(0, 1, 32'h100, 10);
        for (int s = 2; s < NS; s++) set_src(s, s, 32'h200 + s, s);
        in_valid = 6'b111101;
        tick();
        set_src(0, 1, 32'h101, 11);
        in_valid = 6'b000001;
        n_tests++;
        if (in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready1 got %b want 1", in_ready[0]);
        end
        tick();
        n_tests++;
        if (cdb_valid !== 2'b11 || lane0 !== L(2, 2, 2, 32'h202) || lane1 !== L(3, 3, 3, 32'h203)) begin
            n_fail++;
            $display("FAIL b2b_lanes23 got v=%b l0=%h l1=%h", cdb_valid, lane0, lane1);
        end
        set_src(0, 1, 32'h102, 12);
        n_tests++;
        if (in_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full got %b want 0", in_ready[0]);
        end
        tick();
        n_tests++;
        if (cdb_valid !== 2'b11 || lane0 !== L(4, 4, 4, 32'h204) || lane1 !== L(5, 5, 5, 32'h205)) begin
            n_fail++;
            $display("FAIL b2b_lanes45 got v=%b l0=%h l1=%h", cdb_valid, lane0, lane1);
        end
        n_tests++;
        if (in_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full2 got %b want 0", in_ready[0]);
        end
        tick();
        n_tests++;
        if (cdb_valid !== 2'b01 || lane0 !== L(0, 10, 1, 32'h100)) begin
            n_fail++;
            $display("FAIL b2b_first got v=%b l0=%h want 01 %h", cdb_valid, lane0, L(0, 10, 1, 32'h100));
        end
        n_tests++;
        if (in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready2 got %b want 1", in_ready[0]);
        end
        tick();
        in_valid = '0;
        n_tests++;
        if (cdb_valid !== 2'b01 || lane0 !== L(0, 11, 1, 32'h101)) begin
            n_fail++;
            $display("FAIL b2b_second got v=%b l0=%h want 01 %h", cdb_valid, lane0, L(0, 11, 1, 32'h101));
        end
        tick();
        n_tests++;
        if (cdb_valid !== 2'b01 || lane0 !== L(0, 12, 1, 32'h102)) begin
            n_fail++;
            $display("FAIL b2b_third got v=%b l0=%h want 01 %h", cdb_valid, lane0, L(0, 12, 1, 32'h102));
        end
        tick();
        n_tests++;
        if (cdb_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_drained got %b want 00", cdb_valid);
        end
    endtask

    task automatic test_fairness;
        int first_rr;
        logic seen_fp;
        first_rr = -1;
        seen_fp  = 1'b0;
        do_reset();
        set_src(0, 1, 32'h1, 1);
        set_src(1, 2, 32'h2, 2);
        set_src(5, 3, 32'h5, 3);
        in_valid = 6'b100011;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (first_rr < 0 && ((cdb_valid[0] && cdb_src[2:0] == 3'd5) ||
                                 (cdb_valid[1] && cdb_src[5:3] == 3'd5)))
                first_rr = c;
            if ((fp_valid[0] && fp_src[2:0] == 3'd5) || (fp_valid[1] && fp_src[5:3] == 3'd5))
                seen_fp = 1'b1;
        end
        n_tests++;
        if (first_rr != 2) begin
            n_fail++;
            $display("FAIL rr_src5_first got %0d want 2", first_rr);
        end
        n_tests++;
        if (seen_fp !== 1'b0) begin
            n_fail++;
            $display("FAIL fp_src5_starved got %b want 0", seen_fp);
        end
        n_tests++;
        if (fp_valid !== 2'b11 || fp_lane0 !== L(0, 1, 1, 32'h1) || fp_lane1 !== L(1, 2, 2, 32'h2)) begin
            n_fail++;
            $display("FAIL fp_lanes got v=%b l0=%h l1=%h", fp_valid, fp_lane0, fp_lane1);
        end
        in_valid = '0;
    endtask

    task automatic test_squash;
        do_reset();
        for (int s = 2; s < NS; s++) set_src(s, s, 32'h300 + s, s);
        in_valid = 6'b111100;
        tick();
        set_src(0, 9, 32'h399, 9);
        in_valid = 6'b000001;
        squash = 1'b1;
        tick();
        squash = 1'b0;
        in_valid = '0;
        n_tests++;
        if (cdb_valid !== 2'b00 || lane0 !== '0 || lane1 !== '0) begin
            n_fail++;
            $display("FAIL squash_lanes got v=%b l0=%h l1=%h want 0", cdb_valid, lane0, lane1);
        end
        n_tests++;
        if (in_ready !== 6'h3F) begin
            n_fail++;
            $display("FAIL squash_ready got %h want 3f", in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++;
            if (cdb_valid !== 2'b00) begin
                n_fail++;
                $display("FAIL squash_leak c%0d got %b want 00", c, cdb_valid);
            end
        end
        set_src(0, 4, 32'h400, 4);
        set_src(5, 5, 32'h405, 5);
        in_valid = 6'b100001;
        tick();
        in_valid = '0;
        tick();
        n_tests++;
        if (cdb_valid !== 2'b11 || lane0 !== L(0, 4, 4, 32'h400) || lane1 !== L(5, 5, 5, 32'h405)) begin
            n_fail++;
            $display("FAIL squash_rrptr got v=%b l0=%h l1=%h", cdb_valid, lane0, lane1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_all_sources();
        test_back_to_back();
        test_fairness();
        test_squash();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
